// File: rtl/axil_filter_pkg.sv
// rtl/axil_filter_pkg.sv - register map, response codes, types and helpers for the filter CSR block
// Contents:
//   register offsets, rule window base/stride, AXI response codes,
//   rule_t (cfg/key/mask), dec_t (address decode result),
//   write/read FSM state enums, strb_merge(), decode_addr()
package axil_filter_pkg;

  localparam logic [31:0] ADDR_CTRL     = 32'h000;
  localparam logic [31:0] ADDR_ID       = 32'h004;
  localparam logic [31:0] ADDR_ACTION   = 32'h008;
  localparam logic [31:0] ADDR_SCRATCH  = 32'h00C;
  localparam logic [31:0] ADDR_PKT_IN   = 32'h010;
  localparam logic [31:0] ADDR_PKT_PASS = 32'h014;
  localparam logic [31:0] ADDR_PKT_DROP = 32'h018;

  localparam logic [31:0] RULE_BASE   = 32'h100;
  localparam int unsigned RULE_STRIDE = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] cfg;
    logic [31:0] key;
    logic [31:0] mask;
  } rule_t;

  // hit: address is mapped; rule: address falls in a valid rule slot
  typedef struct packed {
    logic       hit;
    logic       rule;
    logic [3:0] idx;
    logic [1:0] field;
  } dec_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Misaligned addresses and the unused fourth word of each rule slot are unmapped.
  function automatic dec_t decode_addr(input logic [31:0] a, input int unsigned nrules);
    dec_t        d;
    logic [31:0] off;
    d       = '0;
    off     = a - RULE_BASE;
    d.idx   = off[7:4];
    d.field = off[3:2];
    if (a >= RULE_BASE && off < nrules * RULE_STRIDE &&
        off[1:0] == 2'b00 && off[3:2] != 2'd3) begin
      d.rule = 1'b1;
      d.hit  = 1'b1;
    end else begin
      case (a)
        ADDR_CTRL, ADDR_ID, ADDR_ACTION, ADDR_SCRATCH,
        ADDR_PKT_IN, ADDR_PKT_PASS, ADDR_PKT_DROP: d.hit = 1'b1;
        default:                                   d.hit = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/axil_filter_rule_bank.sv
// rtl/axil_filter_rule_bank.sv - staged/active rule storage with byte-strobed writes and atomic commit
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en/idx/field/data/strb staged-register write port (field 0 cfg, 1 key, 2 mask)
//   commit                    copy every staged rule to the active set
//   rd_idx/rd_field/rd_data   combinational read of a staged register
//   rule_cfg/key/mask         active rule set, rule r at [32r +: 32]
//   rule_commit               one-cycle pulse, coincident with the active set update
module axil_filter_rule_bank
  import axil_filter_pkg::*;
#(
  parameter int NUM_RULES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [3:0]              wr_idx,
  input  logic [1:0]              wr_field,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_strb,
  input  logic                    commit,
  input  logic [3:0]              rd_idx,
  input  logic [1:0]              rd_field,
  output logic [31:0]             rd_data,
  output logic [NUM_RULES*32-1:0] rule_cfg,
  output logic [NUM_RULES*32-1:0] rule_key,
  output logic [NUM_RULES*32-1:0] rule_mask,
  output logic                    rule_commit
);

  rule_t staged [NUM_RULES];
  rule_t active [NUM_RULES];

  always_ff @(posedge clk) begin
    if (rst) begin
      rule_commit <= 1'b0;
      for (int r = 0; r < NUM_RULES; r++) begin
        staged[r] <= '{cfg: '0, key: '0, mask: '1};
        active[r] <= '{cfg: '0, key: '0, mask: '1};
      end
    end else begin
      rule_commit <= commit;
      for (int r = 0; r < NUM_RULES; r++) begin
        if (commit) begin
          active[r] <= staged[r];
        end
        if (wr_en && wr_idx == 4'(r)) begin
          case (wr_field)
            2'd0:    staged[r].cfg  <= strb_merge(staged[r].cfg,  wr_data, wr_strb);
            2'd1:    staged[r].key  <= strb_merge(staged[r].key,  wr_data, wr_strb);
            2'd2:    staged[r].mask <= strb_merge(staged[r].mask, wr_data, wr_strb);
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_RULES; r++) begin
      if (rd_idx == 4'(r)) begin
        case (rd_field)
          2'd0:    rd_data = staged[r].cfg;
          2'd1:    rd_data = staged[r].key;
          2'd2:    rd_data = staged[r].mask;
          default: rd_data = '0;
        endcase
      end
    end
  end

  always_comb begin
    rule_cfg  = '0;
    rule_key  = '0;
    rule_mask = '0;
    for (int r = 0; r < NUM_RULES; r++) begin
      rule_cfg[32*r +: 32]  = active[r].cfg;
      rule_key[32*r +: 32]  = active[r].key;
      rule_mask[32*r +: 32] = active[r].mask;
    end
  end

endmodule

// File: rtl/axil_filter_csr.sv
// rtl/axil_filter_csr.sv - AXI4-Lite control/status block for the packet filter
// Ports:
//   clk_axil, rst                      clock, synchronous active-high reset
//   s_axil_aw*/w*/b*                   AXI-Lite write channels (decoupled AW/W, WSTRB, SLVERR)
//   s_axil_ar*/r*                      AXI-Lite read channels (1-cycle registered read)
//   cnt_in/cnt_pass/cnt_drop           live datapath counters
//   stats_clr, soft_reset, rule_commit one-cycle pulses
//   filt_en, default_action, print_enable  CTRL fields
//   rule_cfg/rule_key/rule_mask        active rule set, rule r at [32r +: 32]
module axil_filter_csr
  import axil_filter_pkg::*;
#(
  parameter int          NUM_RULES = 4,
  parameter int          ADDR_W    = 12,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] VERSION   = 16'h0002
) (
  input  logic                    clk_axil,
  input  logic                    rst,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [ADDR_W-1:0]       s_axil_awaddr,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  input  logic [31:0]             s_axil_wdata,
  input  logic [3:0]              s_axil_wstrb,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  output logic [1:0]              s_axil_bresp,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  input  logic [ADDR_W-1:0]       s_axil_araddr,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  input  logic [CNT_W-1:0]        cnt_in,
  input  logic [CNT_W-1:0]        cnt_pass,
  input  logic [CNT_W-1:0]        cnt_drop,
  output logic                    stats_clr,
  output logic                    filt_en,
  output logic [1:0]              default_action,
  output logic                    print_enable,
  output logic [NUM_RULES*32-1:0] rule_cfg,
  output logic [NUM_RULES*32-1:0] rule_key,
  output logic [NUM_RULES*32-1:0] rule_mask,
  output logic                    rule_commit,
  output logic                    soft_reset
);

  wstate_t          w_state, w_next;
  rstate_t          r_state, r_next;
  logic             aw_held, w_held;
  logic             aw_hs, w_hs, ar_hs, w_apply;
  logic [31:0]      waddr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      ctrl, scratch;
  logic [CNT_W-1:0] pass_snap, drop_snap;
  logic [31:0]      raddr, rd_word, rd_rule;
  dec_t             wdec, rdec;
  logic             bank_wr, bank_commit;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign raddr = 32'(s_axil_araddr);
  assign wdec  = decode_addr(waddr_q, NUM_RULES);
  assign rdec  = decode_addr(raddr, NUM_RULES);

  assign filt_en        = ctrl[0];
  assign default_action = ctrl[3:2];
  assign print_enable   = ctrl[8];

  always_ff @(posedge clk_axil) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next  = w_state;
    w_apply = 1'b0;
    case (w_state)
      W_IDLE: if (aw_held && w_held) begin
        w_apply = 1'b1;
        w_next  = W_RESP;
      end
      W_RESP: if (s_axil_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    ar_hs  = 1'b0;
    case (r_state)
      R_IDLE: if (s_axil_arvalid && s_axil_arready) begin
        ar_hs  = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: if (s_axil_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign bank_wr     = w_apply && wdec.rule;
  assign bank_commit = w_apply && waddr_q == ADDR_ACTION && wstrb_q[0] && wdata_q[1];

  // Write path: AW and W are captured independently; the write lands in the
  // cycle after both are held, registering bvalid and any pulses together.
  always_ff @(posedge clk_axil) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      ctrl           <= '0;
      scratch        <= '0;
      soft_reset     <= 1'b0;
      stats_clr      <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      stats_clr  <= 1'b0;
      if (w_state == W_IDLE) begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          waddr_q <= 32'(s_axil_awaddr);
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= s_axil_wdata;
          wstrb_q <= s_axil_wstrb;
        end
        s_axil_awready <= !aw_held && !aw_hs;
        s_axil_wready  <= !w_held && !w_hs;
        if (w_apply) begin
          aw_held       <= 1'b0;
          w_held        <= 1'b0;
          s_axil_bvalid <= 1'b1;
          s_axil_bresp  <= wdec.hit ? RESP_OKAY : RESP_SLVERR;
          if (wdec.hit) begin
            case (waddr_q)
              ADDR_CTRL:    ctrl       <= strb_merge(ctrl, wdata_q, wstrb_q);
              ADDR_SCRATCH: scratch    <= strb_merge(scratch, wdata_q, wstrb_q);
              ADDR_ACTION:  soft_reset <= wstrb_q[0] && wdata_q[0];
              ADDR_PKT_IN:  stats_clr  <= wstrb_q[0] && wdata_q[0];
              default:      ;
            endcase
          end
        end
      end else begin
        // Readies reopen in the same edge the response is accepted.
        s_axil_awready <= s_axil_bready;
        s_axil_wready  <= s_axil_bready;
        if (s_axil_bready) s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rdec.rule) begin
      rd_word = rd_rule;
    end else begin
      case (raddr)
        ADDR_CTRL:     rd_word = ctrl;
        ADDR_ID:       rd_word = {8'(NUM_RULES), 8'h00, VERSION};
        ADDR_SCRATCH:  rd_word = scratch;
        ADDR_PKT_IN:   rd_word = 32'(cnt_in);
        ADDR_PKT_PASS: rd_word = 32'(pass_snap);
        ADDR_PKT_DROP: rd_word = 32'(drop_snap);
        default:       rd_word = '0;
      endcase
    end
  end

  // Read data is taken at the AR handshake edge, so a write landing in the
  // same edge is not visible. The PKT_IN read freezes pass/drop alongside it.
  always_ff @(posedge clk_axil) begin
    if (rst) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
      pass_snap      <= '0;
      drop_snap      <= '0;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        s_axil_arready <= 1'b0;
        s_axil_rvalid  <= 1'b1;
        s_axil_rdata   <= rd_word;
        s_axil_rresp   <= rdec.hit ? RESP_OKAY : RESP_SLVERR;
        if (raddr == ADDR_PKT_IN) begin
          pass_snap <= cnt_pass;
          drop_snap <= cnt_drop;
        end
      end else begin
        s_axil_arready <= 1'b1;
      end
    end else if (s_axil_rready) begin
      s_axil_rvalid  <= 1'b0;
      s_axil_arready <= 1'b1;
    end
  end

  axil_filter_rule_bank #(
    .NUM_RULES (NUM_RULES)
  ) u_rule_bank (
    .clk         (clk_axil),
    .rst         (rst),
    .wr_en       (bank_wr),
    .wr_idx      (wdec.idx),
    .wr_field    (wdec.field),
    .wr_data     (wdata_q),
    .wr_strb     (wstrb_q),
    .commit      (bank_commit),
    .rd_idx      (rdec.idx),
    .rd_field    (rdec.field),
    .rd_data     (rd_rule),
    .rule_cfg    (rule_cfg),
    .rule_key    (rule_key),
    .rule_mask   (rule_mask),
    .rule_commit (rule_commit)
  );

endmodule

// File: tb/tb_axil_filter_csr.sv
// tb/tb_axil_filter_csr.sv - directed self-checking bench for axil_filter_csr
module tb_axil_filter_csr;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [11:0]  awaddr = '0, araddr = '0;
  logic [31:0]  wdata = '0, rdata;
  logic [3:0]   wstrb = '0;
  logic [1:0]   bresp, rresp;
  logic [31:0]  cnt_in = '0, cnt_pass = '0, cnt_drop = '0;
  logic         stats_clr, filt_en, print_enable, rule_commit, soft_reset;
  logic [1:0]   default_action;
  logic [127:0] rule_cfg, rule_key, rule_mask;

  int n_checks = 0;
  int n_pass   = 0;
  int n_commit = 0;
  int n_clr    = 0;
  int n_srst   = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rule_commit) n_commit++;
    if (stats_clr)   n_clr++;
    if (soft_reset)  n_srst++;
  end

  axil_filter_csr #(
    .NUM_RULES (4),
    .ADDR_W    (12),
    .CNT_W     (32),
    .VERSION   (16'h0002)
  ) dut (
    .clk_axil       (clk),
    .rst            (rst),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_awaddr  (awaddr),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_bresp   (bresp),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_araddr  (araddr),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .cnt_in         (cnt_in),
    .cnt_pass       (cnt_pass),
    .cnt_drop       (cnt_drop),
    .stats_clr      (stats_clr),
    .filt_en        (filt_en),
    .default_action (default_action),
    .print_enable   (print_enable),
    .rule_cfg       (rule_cfg),
    .rule_key       (rule_key),
    .rule_mask      (rule_mask),
    .rule_commit    (rule_commit),
    .soft_reset     (soft_reset)
  );

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit a_done = 0, d_done = 0, a_hs, d_hs, got = 0;
    resp    = 2'bxx;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int i = 0; i < 20 && !(a_done && d_done); i++) begin
      @(negedge clk);
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) begin awvalid = 1'b0; a_done = 1; end
      if (d_hs) begin wvalid = 1'b0; d_done = 1; end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bvalid) begin got = 1; resp = bresp; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL write_timeout addr=%h", addr);
    end
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit hs = 0, got = 0;
    data    = 32'hDEAD_BEEF;
    resp    = 2'bxx;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    for (int i = 0; i < 20 && !got && hs; i++) begin
      @(negedge clk);
      if (rvalid) begin got = 1; data = rdata; resp = rresp; end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL read_timeout addr=%h", addr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) $display("FAIL reset_handshake got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
    else n_pass++;
    n_checks++;
    if ({filt_en, default_action, print_enable} !== 4'b0) $display("FAIL reset_ctrl got=%b want=0000", {filt_en, default_action, print_enable});
    else n_pass++;
    n_checks++;
    if (rule_mask !== {128{1'b1}}) $display("FAIL reset_mask got=%h want=all-ones", rule_mask);
    else n_pass++;
    n_checks++;
    if (rule_key !== 128'h0 || rule_cfg !== 128'h0) $display("FAIL reset_key_cfg got=%h/%h want=0", rule_key, rule_cfg);
    else n_pass++;
    n_checks++;
    if ({rule_commit, stats_clr, soft_reset} !== 3'b0) $display("FAIL reset_pulses got=%b want=000", {rule_commit, stats_clr, soft_reset});
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    axi_read(12'h004, d, r);
    n_checks++;
    if (d !== 32'h0400_0002 || r !== 2'b00) $display("FAIL read_id got=%h/%b want=04000002/00", d, r);
    else n_pass++;
    axi_read(12'h108, d, r);
    n_checks++;
    if (d !== 32'hFFFF_FFFF || r !== 2'b00) $display("FAIL read_rule0_mask got=%h/%b want=ffffffff/00", d, r);
    else n_pass++;
  endtask

  task automatic test_aw_first();
    bit          hs = 0;
    logic [31:0] d;
    logic [1:0]  r;
    awaddr  = 12'h00C;
    awvalid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk); hs = awready; @(posedge clk); #1;
    end
    awvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wdata  = 32'hA5A5_1234;
    wstrb  = 4'b0011;
    wvalid = 1'b1;
    hs = 0;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk); hs = wready; @(posedge clk); #1;
    end
    wvalid = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0) $display("FAIL aw_first_bvalid_early got=%b want=0", bvalid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) $display("FAIL aw_first_bvalid got=%b/%b want=1/00", bvalid, bresp);
    else n_pass++;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0) $display("FAIL aw_first_bvalid_drop got=%b want=0", bvalid);
    else n_pass++;
    axi_read(12'h00C, d, r);
    n_checks++;
    if (d !== 32'h0000_1234 || r !== 2'b00) $display("FAIL scratch_strb got=%h/%b want=00001234/00", d, r);
    else n_pass++;
  endtask

  task automatic test_commit();
    logic [31:0] d;
    logic [1:0]  r;
    int          c0, s0;
    axi_write(12'h114, 32'h0A00_0001, 4'hF, r);
    n_checks++;
    if (rule_key[63:32] !== 32'h0 || r !== 2'b00) $display("FAIL staged_not_active got=%h/%b want=0/00", rule_key[63:32], r);
    else n_pass++;
    axi_read(12'h114, d, r);
    n_checks++;
    if (d !== 32'h0A00_0001) $display("FAIL staged_readback got=%h want=0a000001", d);
    else n_pass++;
    c0 = n_commit;
    s0 = n_srst;
    axi_write(12'h008, 32'h0000_0002, 4'h1, r);
    n_checks++;
    if (n_commit - c0 !== 1 || n_srst != s0) $display("FAIL commit_pulse got=%0d/%0d want=1/0", n_commit - c0, n_srst - s0);
    else n_pass++;
    n_checks++;
    if (rule_key[63:32] !== 32'h0A00_0001 || rule_key[31:0] !== 32'h0) $display("FAIL commit_active got=%h want=0a000001", rule_key[63:32]);
    else n_pass++;
    axi_write(12'h008, 32'h0000_0001, 4'h1, r);
    n_checks++;
    if (n_srst - s0 !== 1 || n_commit - c0 !== 1) $display("FAIL soft_reset_pulse got=%0d/%0d want=1/1", n_srst - s0, n_commit - c0);
    else n_pass++;
    axi_write(12'h008, 32'h0000_0003, 4'h2, r);
    n_checks++;
    if (n_srst - s0 !== 1 || n_commit - c0 !== 1) $display("FAIL action_no_strb got=%0d/%0d want=1/1", n_srst - s0, n_commit - c0);
    else n_pass++;
    axi_read(12'h008, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== 2'b00) $display("FAIL action_reads_zero got=%h/%b want=0/00", d, r);
    else n_pass++;
  endtask

  task automatic test_stats();
    logic [31:0] d;
    logic [1:0]  r;
    int          k0;
    cnt_in = 32'd100; cnt_pass = 32'd60; cnt_drop = 32'd40;
    axi_read(12'h010, d, r);
    n_checks++;
    if (d !== 32'd100) $display("FAIL pkt_in got=%0d want=100", d);
    else n_pass++;
    cnt_in = 32'd200; cnt_pass = 32'd150; cnt_drop = 32'd50;
    axi_read(12'h014, d, r);
    n_checks++;
    if (d !== 32'd60 || r !== 2'b00) $display("FAIL pkt_pass_snap got=%0d want=60", d);
    else n_pass++;
    axi_read(12'h018, d, r);
    n_checks++;
    if (d !== 32'd40) $display("FAIL pkt_drop_snap got=%0d want=40", d);
    else n_pass++;
    k0 = n_clr;
    axi_write(12'h010, 32'h0000_0001, 4'hF, r);
    n_checks++;
    if (n_clr - k0 !== 1 || r !== 2'b00) $display("FAIL stats_clr_pulse got=%0d/%b want=1/00", n_clr - k0, r);
    else n_pass++;
    axi_write(12'h014, 32'h0000_0001, 4'hF, r);
    n_checks++;
    if (n_clr - k0 !== 1 || r !== 2'b00) $display("FAIL pass_write_ignored got=%0d/%b want=1/00", n_clr - k0, r);
    else n_pass++;
    axi_read(12'h010, d, r);
    axi_read(12'h014, d, r);
    n_checks++;
    if (d !== 32'd150) $display("FAIL pkt_pass_resnap got=%0d want=150", d);
    else n_pass++;
  endtask

  task automatic test_slverr();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(12'h140, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== 2'b10) $display("FAIL read_unmapped got=%h/%b want=0/10", d, r);
    else n_pass++;
    axi_read(12'h10C, d, r);
    n_checks++;
    if (r !== 2'b10) $display("FAIL read_rule_pad got=%b want=10", r);
    else n_pass++;
    axi_write(12'h3FC, 32'hFFFF_FFFF, 4'hF, r);
    n_checks++;
    if (r !== 2'b10) $display("FAIL write_unmapped got=%b want=10", r);
    else n_pass++;
    axi_read(12'h00C, d, r);
    n_checks++;
    if (d !== 32'h0000_1234 || rule_key[63:32] !== 32'h0A00_0001 || filt_en !== 1'b0) $display("FAIL slverr_side_effect got=%h/%h/%b want=00001234/0a000001/0", d, rule_key[63:32], filt_en);
    else n_pass++;
    axi_write(12'h138, 32'h1234_5678, 4'b1100, r);
    axi_read(12'h138, d, r);
    n_checks++;
    if (d !== 32'h1234_FFFF || r !== 2'b00) $display("FAIL rule3_mask_strb got=%h/%b want=1234ffff/00", d, r);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit a_done = 0, d_done = 0, a_hs, d_hs, ok = 1, seen = 0;
    awaddr = 12'h000; wdata = 32'h0000_010D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 20 && !(a_done && d_done); i++) begin
      @(negedge clk); a_hs = awvalid && awready; d_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) begin awvalid = 1'b0; a_done = 1; end
      if (d_hs) begin wvalid = 1'b0; d_done = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = bvalid;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) ok = 0;
    end
    n_checks++;
    if (!ok || !seen) $display("FAIL bready_hold got=%b/%b/%b want=1/0/0", bvalid, awready, wready);
    else n_pass++;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) $display("FAIL bready_release got=%b/%b want=0/1", bvalid, awready);
    else n_pass++;
    n_checks++;
    if ({filt_en, default_action, print_enable} !== 4'b1111) $display("FAIL ctrl_fields got=%b want=1111", {filt_en, default_action, print_enable});
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit          hs = 0;
    logic [31:0] d;
    logic [1:0]  r;
    araddr  = 12'h00C;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk); hs = arready; @(posedge clk); #1;
    end
    arvalid = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1) $display("FAIL mid_read_rvalid got=%b want=1", rvalid);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rvalid !== 1'b0 || rule_key !== 128'h0 || rule_mask !== {128{1'b1}} || filt_en !== 1'b0) $display("FAIL mid_read_reset got=%b/%h/%b want=0/0/0", rvalid, rule_key, filt_en);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    axi_read(12'h00C, d, r);
    n_checks++;
    if (d !== 32'h0) $display("FAIL scratch_after_reset got=%h want=0", d);
    else n_pass++;
    axi_read(12'h114, d, r);
    n_checks++;
    if (d !== 32'h0) $display("FAIL staged_after_reset got=%h want=0", d);
    else n_pass++;
    axi_read(12'h000, d, r);
    n_checks++;
    if (d !== 32'h0) $display("FAIL ctrl_after_reset got=%h want=0", d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_aw_first();
    test_commit();
    test_stats();
    test_slverr();
    test_backpressure();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
